uart_word_loader: RTL and testbench

Receive-side sequencer for the `uart` core. It watches the UART receive strobe and hunts for a sync byte. It then assembles the next two bytes, high byte first, into a 16-bit word and presents it with a one-cycle valid pulse. It also drives the same UART's transmitter to return an ACK or NAK byte for every frame. It sits between a `uart` instance and the host-side register loader, replacing ad-hoc byte counting clocked off `received`.

---
 rtl/uart_word_loader_if.sv | 30 +++
 rtl/uart_word_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_word_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_loader_if.sv
// ============================================================================
// uart_word_loader_if : UART-side and host-side signals of the word loader
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_word_loader_if;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic        is_transmitting;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic [15:0] dout;
  logic        dout_valid;
  logic        frame_error;
  logic        busy;

  modport master (
    input  received, rx_byte, recv_error, is_transmitting,
    output transmit, tx_byte, dout, dout_valid, frame_error, busy
  );

  modport slave (
    output received, rx_byte, recv_error, is_transmitting,
    input  transmit, tx_byte, dout, dout_valid, frame_error, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_word_loader.sv
// ============================================================================
// uart_word_loader : sync-byte framed 16-bit word loader with ACK/NAK reply
// Optional inter-byte timeout: define UART_LOADER_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_word_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'h80,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_word_loader_if.master bus
);

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_LOAD_H     = 3'd1;
  localparam logic [2:0] c_LOAD_L     = 3'd2;
  localparam logic [2:0] c_SEND       = 3'd3;
  localparam logic [2:0] c_WAIT_START = 3'd4;
  localparam logic [2:0] c_WAIT_DONE  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  hold_h_q, hold_h_d;
  logic [15:0] dout_q, dout_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        dout_valid_q, dout_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        transmit_q, transmit_d;

  logic w_in_frame;
  logic w_timeout;
  logic w_abort;

  assign w_in_frame = (state_q == c_LOAD_H) || (state_q == c_LOAD_L);

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int              c_TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

  logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;

  // Zero outside a frame covers the clear on entry to LOAD_H.
  always_comb begin
    to_cnt_d = '0;
    if (w_in_frame && !bus.received) begin
      to_cnt_d = to_cnt_q + c_TO_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign w_timeout = w_in_frame && (to_cnt_q == c_TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 1);
  assign w_timeout        = 1'b0;
`endif

  // A byte landing on the timeout cycle still counts as in time.
  assign w_abort = w_in_frame && (bus.recv_error || (w_timeout && !bus.received));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (bus.received && (bus.rx_byte == SYNC_BYTE)) state_d = c_LOAD_H;
      end
      c_LOAD_H: begin
        if (w_abort)           state_d = c_SEND;
        else if (bus.received) state_d = c_LOAD_L;
      end
      c_LOAD_L: begin
        if (w_abort || bus.received) state_d = c_SEND;
      end
      c_SEND: begin
        if (!bus.is_transmitting) state_d = c_WAIT_START;
      end
      c_WAIT_START: begin
        if (bus.is_transmitting) state_d = c_WAIT_DONE;
      end
      c_WAIT_DONE: begin
        if (!bus.is_transmitting) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    hold_h_d      = hold_h_q;
    dout_d        = dout_q;
    tx_byte_d     = tx_byte_q;
    dout_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    transmit_d    = 1'b0;
    case (state_q)
      c_LOAD_H, c_LOAD_L: begin
        if (w_abort) begin
          frame_error_d = 1'b1;
          tx_byte_d     = NAK_BYTE;
        end else if (bus.received) begin
          if (state_q == c_LOAD_H) begin
            hold_h_d = bus.rx_byte;
          end else begin
            dout_d       = {hold_h_q, bus.rx_byte};
            dout_valid_d = 1'b1;
            tx_byte_d    = ACK_BYTE;
          end
        end
      end
      c_SEND: begin
        transmit_d = !bus.is_transmitting;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_h_q      <= 8'h00;
      dout_q        <= 16'h0000;
      tx_byte_q     <= 8'h00;
      dout_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      transmit_q    <= 1'b0;
    end else begin
      hold_h_q      <= hold_h_d;
      dout_q        <= dout_d;
      tx_byte_q     <= tx_byte_d;
      dout_valid_q  <= dout_valid_d;
      frame_error_q <= frame_error_d;
      transmit_q    <= transmit_d;
    end
  end

  assign bus.transmit    = transmit_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_word_loader.sv
// ============================================================================
// tb_uart_word_loader : scoreboard bench for uart_word_loader with UART model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_word_loader;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_word_loader_if bus();

  uart_word_loader #(
    .SYNC_BYTE     (8'h80),
    .ACK_BYTE      (8'h06),
    .NAK_BYTE      (8'h15),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tx_pulses = 0;
  int last_strobe = 0;

  logic [15:0] exp_dout_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_fe_q[$];

  logic [15:0] m_dout;
  logic [7:0]  m_tx;
  int          m_fe;

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: busy for a few clocks after each transmit
  logic model_busy;
  logic hold_busy;
  int   model_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (bus.transmit) begin
      model_busy <= 1'b1;
      model_cnt  <= 4;
    end else if (model_cnt > 0) begin
      model_cnt <= model_cnt - 1;
    end else begin
      model_busy <= 1'b0;
    end
  end
  assign bus.is_transmitting = model_busy | hold_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dout_valid) begin
        if (exp_dout_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL dout_valid_unexpected actual=%0h expected=none", bus.dout);
        end else begin
          m_dout = exp_dout_q.pop_front();
          chk("dout", {16'h0, bus.dout}, {16'h0, m_dout});
        end
      end
      if (bus.transmit) begin
        tx_pulses++;
        if (exp_tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL transmit_unexpected actual=%0h expected=none", bus.tx_byte);
        end else begin
          m_tx = exp_tx_q.pop_front();
          chk("tx_byte", {24'h0, bus.tx_byte}, {24'h0, m_tx});
        end
      end
      if (bus.frame_error) begin
        if (exp_fe_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL frame_error_unexpected actual=cycle%0d expected=none", cyc);
        end else begin
          m_fe = exp_fe_q.pop_front();
          chk("frame_error_cycle", cyc, m_fe);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err, input int gap);
    bus.received   = 1'b1;
    bus.rx_byte    = b;
    bus.recv_error = err;
    @(posedge clk); #1;
    bus.received   = 1'b0;
    bus.recv_error = 1'b0;
    bus.rx_byte    = 8'h00;
    last_strobe    = cyc;
    if (err) exp_fe_q.push_back(cyc);
    if (gap > 0) idle(gap);
  endtask

  task automatic pulse_err(input logic expect_abort);
    bus.recv_error = 1'b1;
    @(posedge clk); #1;
    bus.recv_error = 1'b0;
    if (expect_abort) exp_fe_q.push_back(cyc);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'h0, bus.busy}, 32'h0);
    idle(2);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_transmit"},    {31'h0, bus.transmit},    32'h0);
    chk({tag, "_tx_byte"},     {24'h0, bus.tx_byte},     32'h0);
    chk({tag, "_dout"},        {16'h0, bus.dout},        32'h0);
    chk({tag, "_dout_valid"},  {31'h0, bus.dout_valid},  32'h0);
    chk({tag, "_frame_error"}, {31'h0, bus.frame_error}, 32'h0);
    chk({tag, "_busy"},        {31'h0, bus.busy},        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    bus.received   = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.recv_error = 1'b0;
    hold_busy      = 1'b0;
    rst_n          = 1'b0;
    idle(3);
    check_reset("rst");
    rst_n = 1'b1;
    idle(1);

    // Good frame; bytes arriving during SEND/WAIT_START are dropped
    exp_dout_q.push_back(16'h1234); exp_tx_q.push_back(8'h06);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h12, 1'b0, 3);
    send_byte(8'h34, 1'b0, 0);
    send_byte(8'h80, 1'b0, 0);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    wait_idle("good_busy_drop");
    chk("good_dout_hold", {16'h0, bus.dout}, 32'h1234);

    // Garbage before sync
    exp_dout_q.push_back(16'hABCD); exp_tx_q.push_back(8'h06);
    send_byte(8'h55, 1'b0, 3);
    send_byte(8'h12, 1'b0, 3);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'hAB, 1'b0, 3);
    send_byte(8'hCD, 1'b0, 3);
    wait_idle("garbage_idle");

    // Sync value accepted as high data byte
    exp_dout_q.push_back(16'h8005); exp_tx_q.push_back(8'h06);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h05, 1'b0, 3);
    wait_idle("syncdata_idle");

    // Framing error in LOAD_L
    exp_tx_q.push_back(8'h15);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h77, 1'b0, 3);
    pulse_err(1'b1);
    wait_idle("ferr_idle");
    chk("ferr_dout_kept", {16'h0, bus.dout}, 32'h8005);

    // recv_error together with received in LOAD_H: error wins
    exp_tx_q.push_back(8'h15);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h99, 1'b1, 3);
    wait_idle("errwin_idle");
    chk("errwin_dout_kept", {16'h0, bus.dout}, 32'h8005);

    // recv_error in IDLE is ignored
    pulse_err(1'b0);
    idle(5);
    chk("idle_err_ignored", {31'h0, bus.busy}, 32'h0);

    // Timeout after the high byte
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h12, 1'b0, 0);
`ifdef UART_LOADER_TIMEOUT_EN
    exp_fe_q.push_back(last_strobe + TO);
    exp_tx_q.push_back(8'h15);
    wait_idle("timeout_idle");
`else
    idle(40);
    chk("no_timeout_busy", {31'h0, bus.busy}, 32'h1);
    exp_tx_q.push_back(8'h15);
    pulse_err(1'b1);
    wait_idle("no_timeout_idle");
`endif
    chk("timeout_dout_kept", {16'h0, bus.dout}, 32'h8005);

    // Busy transmitter stalls SEND
    hold_busy = 1'b1;
    exp_dout_q.push_back(16'h5A5A); exp_tx_q.push_back(8'h06);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h5A, 1'b0, 3);
    send_byte(8'h5A, 1'b0, 0);
    p = tx_pulses;
    idle(10);
    chk("stall_no_tx", tx_pulses, p);
    chk("stall_busy", {31'h0, bus.busy}, 32'h1);
    hold_busy = 1'b0;
    wait_idle("stall_idle");
    chk("stall_one_tx", tx_pulses, p + 1);

    // Reset mid-frame
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h12, 1'b0, 1);
    rst_n = 1'b0;
    #2;
    check_reset("midrst");
    idle(3);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_no_tx", {31'h0, bus.transmit}, 32'h0);
    exp_dout_q.push_back(16'h0001); exp_tx_q.push_back(8'h06);
    send_byte(8'h80, 1'b0, 3);
    send_byte(8'h00, 1'b0, 3);
    send_byte(8'h01, 1'b0, 3);
    wait_idle("postrst_idle");

    idle(5);
    chk("dout_queue_empty", exp_dout_q.size(), 0);
    chk("tx_queue_empty",   exp_tx_q.size(),   0);
    chk("fe_queue_empty",   exp_fe_q.size(),   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
